regfile_write_buffer: RTL and testbench

//  Write-side companion of the register file: queues register writebacks from two

---
 rtl/regfile_write_buffer.sv | 106 ++++++++++
 tb/tb_regfile_write_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// Write-back queue between the execute/memory producers and the single RegFile write port.
// Define WB_BYPASS_EN to forward still-queued values onto the RegFile read data.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_reg,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WD3,
    output logic          WE3,
    input  logic [AW-1:0] ReadReg1,
    input  logic [AW-1:0] ReadReg2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [CW-1:0] pending
);

    logic [AW-1:0] reg_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] alu_slot;
    logic          mem_store, alu_store, pop;

    // Readiness looks only at the registered count; a pop in the same cycle is not credited.
    assign mem_ready = (count_q < CW'(DEPTH));
    assign alu_ready = mem_valid ? (count_q <= CW'(DEPTH - 2)) : (count_q < CW'(DEPTH));

    // Register 0 writes complete the handshake but never occupy a slot.
    assign mem_store = mem_valid & mem_ready & (mem_reg != '0);
    assign alu_store = alu_valid & alu_ready & (alu_reg != '0);
    assign pop       = (count_q != '0);

    // The load entry is older than a same-cycle ALU entry, so it takes the first slot.
    assign alu_slot  = wr_ptr_q + PW'(mem_store);
    assign wr_ptr_d  = wr_ptr_q + PW'(mem_store) + PW'(alu_store);
    assign rd_ptr_d  = rd_ptr_q + PW'(pop);
    assign count_d   = count_q + CW'(mem_store) + CW'(alu_store) - CW'(pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_store) begin
            reg_mem[wr_ptr_q]  <= mem_reg;
            data_mem[wr_ptr_q] <= mem_data;
        end
        if (alu_store) begin
            reg_mem[alu_slot]  <= alu_reg;
            data_mem[alu_slot] <= alu_data;
        end
    end

    assign WE3      = pop;
    assign WriteReg = pop ? reg_mem[rd_ptr_q]  : '0;
    assign WD3      = pop ? data_mem[rd_ptr_q] : '0;
    assign pending  = count_q;

`ifdef WB_BYPASS_EN
    // Scan from head to tail so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] byp_idx;
        byp_idx = '0;
        rd1     = rf_rd1;
        rd2     = rf_rd2;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if ((ReadReg1 != '0) && (reg_mem[byp_idx] == ReadReg1)) rd1 = data_mem[byp_idx];
                if ((ReadReg2 != '0) && (reg_mem[byp_idx] == ReadReg2)) rd2 = data_mem[byp_idx];
            end
        end
    end
`else
    logic unused_read_regs;
    assign unused_read_regs = ^{ReadReg1, ReadReg2};
    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_reg = '0, mem_reg = '0, ReadReg1 = '0, ReadReg2 = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0, rf_rd1 = '0, rf_rd2 = '0;
    logic          alu_ready, mem_ready, WE3;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WD3, rd1, rd2;
    logic [CW-1:0] pending;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } entry_t;
    entry_t model_q[$];

    regfile_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .WriteReg(WriteReg), .WD3(WD3), .WE3(WE3),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rd1(rd1), .rd2(rd2), .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_mem_ready();
        return model_q.size() < DEPTH;
    endfunction

    function automatic bit exp_alu_ready();
        return mem_valid ? (model_q.size() <= DEPTH - 2) : (model_q.size() < DEPTH);
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] addr, input logic [DW-1:0] rf);
        logic [DW-1:0] r;
        r = rf;
`ifdef WB_BYPASS_EN
        if (addr != 0)
            foreach (model_q[i]) if (model_q[i].r == addr) r = model_q[i].d;
`endif
        return r;
    endfunction

    // Reference model: a plain queue of pending writes in acceptance order.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            model_q.delete();
        end else begin
            bit mr, ar;
            mr = exp_mem_ready();
            ar = exp_alu_ready();
            if (model_q.size() != 0) void'(model_q.pop_front());
            if (mem_valid && mr && mem_reg != 0) model_q.push_back('{mem_reg, mem_data});
            if (alu_valid && ar && alu_reg != 0) model_q.push_back('{alu_reg, alu_data});
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("pending", DW'(pending), DW'(model_q.size()));
            chk("WE3", DW'(WE3), DW'(model_q.size() != 0));
            chk("WriteReg", DW'(WriteReg), model_q.size() != 0 ? DW'(model_q[0].r) : '0);
            chk("WD3", WD3, model_q.size() != 0 ? model_q[0].d : '0);
            chk("mem_ready", DW'(mem_ready), DW'(exp_mem_ready()));
            chk("alu_ready", DW'(alu_ready), DW'(exp_alu_ready()));
            chk("rd1", rd1, model_rd(ReadReg1, rf_rd1));
            chk("rd2", rd2, model_rd(ReadReg2, rf_rd2));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    typedef struct {
        logic          av;
        logic [AW-1:0] ar;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] mr;
        logic [DW-1:0] md;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b1, 5'd10, 32'h0000_00A0, 1'b1, 5'd11, 32'h0000_00B0},
        '{1'b1, 5'd12, 32'h0000_00C0, 1'b1, 5'd13, 32'h0000_00D0},
        '{1'b1, 5'd14, 32'h0000_00E0, 1'b1, 5'd15, 32'h0000_00F0},
        '{1'b1, 5'd0,  32'h0000_0001, 1'b1, 5'd16, 32'h8000_0000},
        '{1'b0, 5'd17, 32'h0000_0002, 1'b1, 5'd0,  32'h0000_0003},
        '{1'b1, 5'd18, 32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0000_0000},
        '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'h7FFF_FFFF},
        '{1'b1, 5'd31, 32'h1234_0000, 1'b1, 5'd30, 32'h0000_4321},
        '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000},
        '{1'b1, 5'd1,  32'h0000_0077, 1'b0, 5'd0,  32'h0000_0000}
    };

    initial begin
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("rst_WE3", DW'(WE3), 32'd0);
        chk("rst_pending", DW'(pending), 32'd0);
        chk("rst_WriteReg", DW'(WriteReg), 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_alu_ready", DW'(alu_ready), 32'd1);
        chk("rst_mem_ready", DW'(mem_ready), 32'd1);
        #1 reset_n = 1'b1;

        // Single ALU write
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, '0);
        step(); idle();
        @(negedge clock);
        chk("single_WE3", DW'(WE3), 32'd1);
        chk("single_WriteReg", DW'(WriteReg), 32'd5);
        chk("single_WD3", WD3, 32'h1234_5678);
        step();
        @(negedge clock);
        chk("single_pending_drained", DW'(pending), 32'd0);
        chk("single_WE3_low", DW'(WE3), 32'd0);

        // Dual producer to the same register: load first, then ALU
        drive(1'b1, 5'd3, 32'd42, 1'b1, 5'd3, 32'hFFFF_FFF9);
        step(); idle();
        @(negedge clock);
        chk("dual_first_reg", DW'(WriteReg), 32'd3);
        chk("dual_first_data", WD3, 32'hFFFF_FFF9);
        chk("dual_pending", DW'(pending), 32'd2);
        step();
        @(negedge clock);
        chk("dual_second_data", WD3, 32'd42);
        step();

        // Backpressure at DEPTH-1
        drive(1'b1, 5'd2, 32'd20, 1'b1, 5'd1, 32'd10);
        step();
        drive(1'b1, 5'd6, 32'd60, 1'b1, 5'd4, 32'd40);
        step();
        drive(1'b1, 5'd9, 32'd90, 1'b1, 5'd8, 32'd80);
        @(negedge clock);
        chk("bp_pending", DW'(pending), 32'd3);
        chk("bp_mem_ready", DW'(mem_ready), 32'd1);
        chk("bp_alu_ready", DW'(alu_ready), 32'd0);
        step();
        mem_valid = 1'b0;
        @(negedge clock);
        chk("bp_retry_ready", DW'(alu_ready), 32'd1);
        step(); idle();
        @(negedge clock);
        chk("bp_head_after_retry", DW'(WriteReg), 32'd6);
        chk("bp_pending_after_retry", DW'(pending), 32'd3);
        step();
        @(negedge clock);
        chk("bp_order_mem", DW'(WriteReg), 32'd8);
        step();
        @(negedge clock);
        chk("bp_order_alu", DW'(WriteReg), 32'd9);
        chk("bp_order_alu_data", WD3, 32'd90);
        step();

        // Register 0 write is absorbed
        drive(1'b1, 5'd0, 32'd99, 1'b0, 5'd0, '0);
        @(negedge clock);
        chk("r0_alu_ready", DW'(alu_ready), 32'd1);
        step(); idle();
        @(negedge clock);
        chk("r0_pending", DW'(pending), 32'd0);
        chk("r0_WE3", DW'(WE3), 32'd0);

        // Forwarding of queued values
        drive(1'b1, 5'd7, 32'd2, 1'b1, 5'd7, 32'd1);
        ReadReg1 = 5'd7; rf_rd1 = 32'd0;
        ReadReg2 = 5'd0; rf_rd2 = 32'h0000_0055;
        step(); idle();
        @(negedge clock);
`ifdef WB_BYPASS_EN
        chk("byp_rd1_youngest", rd1, 32'd2);
`else
        chk("byp_rd1_wire", rd1, 32'd0);
`endif
        chk("byp_rd2_r0", rd2, 32'h0000_0055);
        step();
        step();
        @(negedge clock);
        chk("byp_rd1_empty", rd1, 32'd0);
        ReadReg1 = 5'd0;

        // Reset mid-drain with three entries queued
        drive(1'b1, 5'd2, 32'd22, 1'b1, 5'd1, 32'd11);
        step();
        drive(1'b1, 5'd4, 32'd44, 1'b1, 5'd3, 32'd33);
        step(); idle();
        @(negedge clock);
        chk("mid_pending_before_rst", DW'(pending), 32'd3);
        step();
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_WE3", DW'(WE3), 32'd0);
        chk("mid_rst_pending", DW'(pending), 32'd0);
        @(negedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("mid_rst_alu_ready", DW'(alu_ready), 32'd1);
        chk("mid_rst_WE3_after", DW'(WE3), 32'd0);

        // Directed vector table, checked every cycle by the model
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
            ReadReg1 = vecs[i].ar;
            ReadReg2 = vecs[i].mr;
            rf_rd1   = 32'hAAAA_0000 + 32'(i);
            rf_rd2   = 32'h5555_0000 + 32'(i);
            step();
        end
        idle();
        for (int i = 0; i < 6; i++) step();
        @(negedge clock);
        chk("final_pending", DW'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
